// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches from a combinational
// instruction memory into a small in-order buffer, and hands words to decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic [31:0] InstrOut,
  output logic [31:0] PCOut,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        Halt,
  output logic        Halted,
  output logic        Misaligned
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_FETCH, S_HALTED} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t                      state_q, state_d;
  entry_t [BUF_DEPTH-1:0]      ent_q, ent_d;
  logic   [31:0]               pc_q, pc_d;
  logic   [CW-1:0]             cnt_q, cnt_d;
  logic   [PW-1:0]             head_q, head_d, tail_q, tail_d;
  logic                        mis_q, mis_d;
  logic                        pop, push;

  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    mis_d   = mis_q;
    pop     = (cnt_q != '0) & InstrReady;
    // A full buffer still accepts a word when the head leaves the same cycle.
    push    = (state_q == S_FETCH) & ~Redirect & ~Halt &
              ((cnt_q != CW'(BUF_DEPTH)) | pop);
    if (Redirect) begin
      cnt_d  = '0;
      head_d = '0;
      tail_d = '0;
      if (RedirectTarget[1:0] == 2'b00) begin
        pc_d    = RedirectTarget;
        state_d = S_FETCH;
      end else begin
        mis_d   = 1'b1;
        state_d = S_HALTED;
      end
    end else begin
      if (pop) head_d = head_q + PW'(1);
      if (push) begin
        ent_d[tail_q] = '{instr: Instruction, pc: pc_q};
        tail_d        = tail_q + PW'(1);
        pc_d          = pc_q + 32'd4;
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (state_q == S_FETCH && Halt) state_d = S_HALTED;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      ent_q   <= '0;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      mis_q   <= mis_d;
    end
  end

  assign Address    = pc_q;
  assign InstrOut   = ent_q[head_q].instr;
  assign PCOut      = ent_q[head_q].pc;
  assign InstrValid = (cnt_q != '0);
  assign Halted     = (state_q == S_HALTED);
  assign Misaligned = mis_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, a wrap-around sequence on a
// second instance, then random traffic against a queue-based reference model.
module tb_fetch_sequencer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, rdy, rdr, hlt;
  logic [31:0] tgt;
  logic [31:0] addr, ins, iout, pcout;
  logic        ival, hd, mis;
  logic [31:0] addr2, ins2, iout2, pcout2;
  logic        ival2, hd2, mis2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0: return 32'h8e68_0021;
      32'h4: return 32'h8e68_0020;
      32'h8: return 32'h2272_0004;
      default: return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
    endcase
  endfunction

  assign ins  = mem(addr);
  assign ins2 = mem(addr2);

  fetch_sequencer #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .Clk(clk), .Reset(rst), .Address(addr), .Instruction(ins),
    .InstrOut(iout), .PCOut(pcout), .InstrValid(ival), .InstrReady(rdy),
    .Redirect(rdr), .RedirectTarget(tgt), .Halt(hlt), .Halted(hd),
    .Misaligned(mis));

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(DEPTH)) dut2 (
    .Clk(clk), .Reset(rst), .Address(addr2), .Instruction(ins2),
    .InstrOut(iout2), .PCOut(pcout2), .InstrValid(ival2), .InstrReady(rdy),
    .Redirect(rdr), .RedirectTarget(tgt), .Halt(hlt), .Halted(hd2),
    .Misaligned(mis2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic y, input logic d,
                       input logic [31:0] t, input logic h);
    rst = r; rdy = y; rdr = d; tgt = t; hlt = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: inputs applied for one cycle, outputs checked after the edge.
  typedef struct {
    string       nm;
    logic        rst, rdy, rdr;
    logic [31:0] tgt;
    logic        hlt;
    logic        v;
    logic [31:0] pc, ins, addr;
    logic        hd, mis;
  } vec_t;
  vec_t vt[$];

  task automatic add(input string nm, input logic r, input logic y, input logic d,
                     input logic [31:0] t, input logic h, input logic v,
                     input logic [31:0] pc, input logic [31:0] i,
                     input logic [31:0] a, input logic ehd, input logic emis);
    vec_t e;
    e.nm = nm; e.rst = r; e.rdy = y; e.rdr = d; e.tgt = t; e.hlt = h;
    e.v = v; e.pc = pc; e.ins = i; e.addr = a; e.hd = ehd; e.mis = emis;
    vt.push_back(e);
  endtask

  // Reference model: a plain queue of fetched words plus PC and two flags.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ment_t;
  ment_t       mq[$];
  logic [31:0] m_pc;
  logic        m_halt, m_mis;

  task automatic model_step(input logic r, input logic y, input logic d,
                            input logic [31:0] t, input logic h);
    logic  popped;
    ment_t e;
    if (r) begin
      mq.delete(); m_pc = 32'h0; m_halt = 1'b0; m_mis = 1'b0;
    end else if (d) begin
      mq.delete();
      if (t[1:0] == 2'b00) begin
        m_pc = t; m_halt = 1'b0;
      end else begin
        m_mis = 1'b1; m_halt = 1'b1;
      end
    end else begin
      popped = (mq.size() > 0) && y;
      if (popped) void'(mq.pop_front());
      if (!m_halt) begin
        if (h) m_halt = 1'b1;
        else if (mq.size() < DEPTH) begin
          e.pc = m_pc; e.ins = mem(m_pc);
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  localparam logic [31:0] I0 = 32'h8e68_0021;
  localparam logic [31:0] I4 = 32'h8e68_0020;
  localparam logic [31:0] I8 = 32'h2272_0004;

  initial begin
    drive(1, 1, 0, 0, 0);
    // basic streaming
    add("rstA",   1,1,0,0,0, 0,0,0,0,0,0);
    add("strm0",  0,1,0,0,0, 1,0,I0,4,0,0);
    add("strm1",  0,1,0,0,0, 1,4,I4,8,0,0);
    add("strm2",  0,1,0,0,0, 1,8,I8,32'hC,0,0);
    // backpressure then release
    add("rstB",   1,1,0,0,0, 0,0,0,0,0,0);
    add("bp1",    0,0,0,0,0, 1,0,I0,4,0,0);
    add("bp2",    0,0,0,0,0, 1,0,I0,8,0,0);
    add("bp3",    0,0,0,0,0, 1,0,I0,8,0,0);
    add("bp4",    0,0,0,0,0, 1,0,I0,8,0,0);
    add("bp5",    0,0,0,0,0, 1,0,I0,8,0,0);
    add("rel1",   0,1,0,0,0, 1,4,I4,32'hC,0,0);
    add("rel2",   0,1,0,0,0, 1,8,I8,32'h10,0,0);
    // redirect with full buffer
    add("rstC",   1,1,0,0,0, 0,0,0,0,0,0);
    add("fill1",  0,0,0,0,0, 1,0,I0,4,0,0);
    add("fill2",  0,0,0,0,0, 1,0,I0,8,0,0);
    add("redir4", 0,0,1,4,0, 0,0,0,4,0,0);
    add("tgt4",   0,0,0,0,0, 1,4,I4,8,0,0);
    add("tgt8",   0,1,0,0,0, 1,8,I8,32'hC,0,0);
    // misaligned redirect, then recovery
    add("mis6",   0,1,1,6,0, 0,0,0,32'hC,1,1);
    add("misHld", 0,1,0,0,0, 0,0,0,32'hC,1,1);
    add("rec0",   0,1,1,0,0, 0,0,0,0,0,1);
    add("recv",   0,1,0,0,0, 1,0,I0,4,0,1);
    // halt drains buffer, redirect beats halt
    add("rstE",   1,1,0,0,0, 0,0,0,0,0,0);
    add("hfill1", 0,0,0,0,0, 1,0,I0,4,0,0);
    add("hfill2", 0,0,0,0,0, 1,0,I0,8,0,0);
    add("halt",   0,0,0,0,1, 1,0,I0,8,1,0);
    add("drain1", 0,1,0,0,0, 1,4,I4,8,1,0);
    add("drain2", 0,1,0,0,0, 0,0,0,8,1,0);
    add("hidle",  0,1,0,0,0, 0,0,0,8,1,0);
    add("hrdr8",  0,1,1,8,1, 0,0,0,8,0,0);
    add("res8",   0,1,0,0,0, 1,8,I8,32'hC,0,0);
    add("frdr0",  0,1,1,0,1, 0,0,0,0,0,0);
    add("res0",   0,1,0,0,0, 1,0,I0,4,0,0);
    add("rstOvr", 1,1,1,8,1, 0,0,0,0,0,0);
    add("mis2",   0,1,1,2,0, 0,0,0,0,1,1);
    add("rstMis", 1,1,0,0,0, 0,0,0,0,0,0);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].rdy, vt[i].rdr, vt[i].tgt, vt[i].hlt);
      tick();
      chk({vt[i].nm, ".addr"},  addr, vt[i].addr);
      chk({vt[i].nm, ".valid"}, {31'b0, ival}, {31'b0, vt[i].v});
      chk({vt[i].nm, ".halted"}, {31'b0, hd}, {31'b0, vt[i].hd});
      chk({vt[i].nm, ".mis"},   {31'b0, mis}, {31'b0, vt[i].mis});
      if (vt[i].v || vt[i].rst) begin
        chk({vt[i].nm, ".pcout"}, pcout, vt[i].pc);
        chk({vt[i].nm, ".instr"}, iout,  vt[i].ins);
      end
    end

    // PC wrap on the second instance, then mid-stream reset clears everything
    drive(1, 1, 0, 0, 0); tick();
    chk("wrap.rstaddr", addr2, 32'hFFFF_FFF8);
    drive(0, 1, 0, 0, 0); tick();
    chk("wrap.pc0", pcout2, 32'hFFFF_FFF8);
    chk("wrap.ins0", iout2, mem(32'hFFFF_FFF8));
    chk("wrap.v0", {31'b0, ival2}, 32'd1);
    tick();
    chk("wrap.pc1", pcout2, 32'hFFFF_FFFC);
    tick();
    chk("wrap.pc2", pcout2, 32'h0000_0000);
    chk("wrap.ins2", iout2, I0);
    chk("wrap.addr", addr2, 32'h4);
    drive(0, 1, 1, 32'h6, 0); tick();
    chk("wrap.mis", {31'b0, mis2}, 32'd1);
    drive(0, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0); tick();
    chk("wrapRst.addr",  addr2, 32'hFFFF_FFF8);
    chk("wrapRst.valid", {31'b0, ival2}, 32'd0);
    chk("wrapRst.pcout", pcout2, 32'd0);
    chk("wrapRst.instr", iout2, 32'd0);
    chk("wrapRst.halted", {31'b0, hd2}, 32'd0);
    chk("wrapRst.mis",   {31'b0, mis2}, 32'd0);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic        r, y, d, h;
      logic [31:0] t;
      r = (c == 0) || ($urandom_range(0, 199) == 0);
      y = $urandom_range(0, 1) == 1;
      d = $urandom_range(0, 11) == 0;
      h = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0;
      else t = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
      drive(r, y, d, t, h);
      model_step(r, y, d, t, h);
      tick();
      chk("rnd.addr",   addr, m_pc);
      chk("rnd.valid",  {31'b0, ival}, {31'b0, mq.size() > 0});
      chk("rnd.halted", {31'b0, hd},  {31'b0, m_halt});
      chk("rnd.mis",    {31'b0, mis}, {31'b0, m_mis});
      if (mq.size() > 0) begin
        chk("rnd.pcout", pcout, mq[0].pc);
        chk("rnd.instr", iout,  mq[0].ins);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the MIPS32 core. It owns the program counter, drives the instruction memory address, and captures each returned word into a small in-order buffer. It presents the buffered words to decode with a valid/ready handshake and accepts redirects from branch/jump resolution. It sits between the combinational instruction memory and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- BUF_DEPTH, 2, instruction buffer entries; power of two, ≥2.
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- Address  out  32  instruction memory address; equals the PC register.
- Instruction  in  32  instruction memory data; combinational response to Address in the same cycle.
- InstrOut  out  32  instruction at the buffer head.
- PCOut  out  32  address the head instruction was fetched from.
- InstrValid  out  1  buffer non-empty.
- InstrReady  in  1  decode accepts the head this cycle.
- Redirect  in  1  load a new PC and flush the buffer (single-cycle pulse).
- RedirectTarget  in  32  new PC when Redirect=1.
- Halt  in  1  stop fetching; sampled each cycle.
- Halted  out  1  state is HALTED.
- Misaligned  out  1  sticky error: a redirect target had bits [1:0] ≠ 0.

## Operation
- States: FETCH, HALTED. Reset state is FETCH.
- pop = InstrValid & InstrReady. The head is removed on the next edge.
- push = (state==FETCH) & ~Redirect & ~Halt & (count<BUF_DEPTH | pop).
  - On push, {Instruction, Address} is written at the tail.
  - PC ← PC+4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Simultaneous push and pop when the buffer is full is legal. Count is unchanged and no entry is lost.
- Aligned redirect (Redirect=1, RedirectTarget[1:0]==0), in any state:
  - Buffer is flushed (count←0).
  - PC ← RedirectTarget.
  - State ← FETCH.
  - Any same-cycle pop or push is discarded.
- Misaligned redirect (Redirect=1, RedirectTarget[1:0]≠0):
  - Buffer is flushed.
  - PC is unchanged.
  - Misaligned ← 1.
  - State ← HALTED.
- Halt=1 with Redirect=0 in FETCH:
  - No push that cycle.
  - State ← HALTED.
  - The buffer continues to drain through pops.
- Redirect has priority over Halt when both are asserted in the same cycle.
- HALTED:
  - No pushes; PC is held.
  - Exits only on an aligned Redirect.
- Misaligned clears only on Reset.
- Reset values:
  - PC = RESET_PC, so Address = RESET_PC.
  - count = 0 and InstrValid = 0.
  - InstrOut = 0 and PCOut = 0.
  - Halted = 0 and Misaligned = 0.
  - State = FETCH.
- Reset asserted mid-operation overrides Redirect, Halt and handshake inputs in that cycle.

## Timing
- Address is a registered output. It changes only on a clock edge.
- Fetch-to-valid latency: a word pushed at edge N is visible with InstrValid=1 after edge N.
  - After reset deasserts, the first InstrValid=1 appears one cycle later, with PCOut = RESET_PC.
- Sustained throughput is one instruction per cycle when InstrReady stays high.
- Redirect latency: Redirect at edge N gives Address = target after N, and InstrValid=0 for exactly that cycle. The target instruction is valid after edge N+1.
- Backpressure: with InstrReady=0, the buffer fills in BUF_DEPTH cycles. PC then stalls on the next unfetched address.
- InstrOut and PCOut are stable whenever InstrValid=1 and InstrReady=0.

## Test plan
- Reset with RESET_PC=0, memory image {0x00:8e680021, 0x04:8e680020, 0x08:22720004}, InstrReady=1. Expect consecutive PCOut/InstrOut pairs 0x00/8e680021, 0x04/8e680020, 0x08/22720004, with InstrValid=1 from the first cycle after reset.
- Hold InstrReady=0 for 5 cycles after reset. Expect count=2, Address held at 0x08, and the head held at 0x00/8e680021. Then release: expect 0x00, 0x04, 0x08 in order with no gap or duplicate.
- With the buffer full, pulse Redirect with target 0x04. Expect InstrValid=0 for one cycle, then PCOut=0x04, InstrOut=8e680020. The old entries are never presented.
- Redirect with target 0x06. Expect Misaligned=1, Halted=1, InstrValid=0 the next cycle, and Address unchanged. A later Redirect to 0x00 resumes fetch; Misaligned stays 1 until Reset.
- Assert Halt for one cycle while InstrReady=1. Expect Halted=1, the buffer drains to empty, and no new pushes. Assert Halt and Redirect(0x08) together: expect FETCH state with PCOut 0x08 next.
- Use RESET_PC=32'hFFFF_FFF8 and assert Reset mid-stream. Expect PCOut sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Reset asserted mid-sequence returns all outputs to their reset values on the next edge.
